// File: rtl/ex_fwd_stage_reg.sv
// ---------------------------------------------------------------------------
// ex_fwd_stage_reg
//
// Execute-stage pipeline register with an integrated operand-forwarding
// network. Operands are resolved combinationally from a prioritised list of
// bypass sources and handed to the external ALU. The ALU result and the
// instruction sideband are then registered for the memory stage.
//
// Bypass sources, highest priority first:
//   S0            : this stage's own output register (out_valid & out_we)
//   S1..S_NUM_FWD : external sources fwd[0..NUM_FWD-1] (fwd_we[i])
//   fallback      : register-file read data (in_rs_data / in_rt_data)
// The first active source whose destination matches the operand index wins.
// If that source's result is not ready yet (t != 0), the operand raises a
// hazard. Lower-priority matches never mask this, because they hold older
// values of the same register.
//
// Ports:
//   Clk, Clr              clock (rising edge), asynchronous active-high clear
//   flush                 synchronous exception flush
//   mc_busy               multi-cycle unit busy; blocks capture
//   in_valid / in_ready   upstream handshake
//   in_pc, in_rs_id, in_rt_id, in_rs_data, in_rt_data, in_t, in_we,
//   in_reg_id, in_payload instruction presented by decode
//   fwd_we, fwd_t, fwd_reg_id, fwd_data
//                         packed external bypass sources, slice i at
//                         [i*W +: W]
//   op_rs, op_rt          forwarded operands to the ALU (combinational)
//   alu_result            ALU/XALU result for the current in_* instruction
//   hazard                operand not yet available (combinational)
//   out_valid / out_ready downstream handshake
//   out_pc, out_store_data, out_data, out_t, out_we, out_reg_id,
//   out_payload           registered instruction for the memory stage
// ---------------------------------------------------------------------------
module ex_fwd_stage_reg #(
  parameter int DATA_W    = 32,
  parameter int REG_ID_W  = 5,
  parameter int T_W       = 4,
  parameter int NUM_FWD   = 2,
  parameter int PAYLOAD_W = 64
) (
  input  logic                        Clk,
  input  logic                        Clr,
  input  logic                        flush,
  input  logic                        mc_busy,

  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_pc,
  input  logic [REG_ID_W-1:0]         in_rs_id,
  input  logic [REG_ID_W-1:0]         in_rt_id,
  input  logic [DATA_W-1:0]           in_rs_data,
  input  logic [DATA_W-1:0]           in_rt_data,
  input  logic [T_W-1:0]              in_t,
  input  logic                        in_we,
  input  logic [REG_ID_W-1:0]         in_reg_id,
  input  logic [PAYLOAD_W-1:0]        in_payload,

  input  logic [NUM_FWD-1:0]          fwd_we,
  input  logic [NUM_FWD*T_W-1:0]      fwd_t,
  input  logic [NUM_FWD*REG_ID_W-1:0] fwd_reg_id,
  input  logic [NUM_FWD*DATA_W-1:0]   fwd_data,

  output logic [DATA_W-1:0]           op_rs,
  output logic [DATA_W-1:0]           op_rt,
  input  logic [DATA_W-1:0]           alu_result,
  output logic                        hazard,

  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_pc,
  output logic [DATA_W-1:0]           out_store_data,
  output logic [DATA_W-1:0]           out_data,
  output logic [T_W-1:0]              out_t,
  output logic                        out_we,
  output logic [REG_ID_W-1:0]         out_reg_id,
  output logic [PAYLOAD_W-1:0]        out_payload
);

  // Own output register plus the external sources.
  localparam int NSRC = NUM_FWD + 1;

  // Number of operands resolved by the forwarding network (rs, rt).
  localparam int NUM_OPND = 2;

  typedef struct packed {
    logic              haz;
    logic [DATA_W-1:0] val;
  } opnd_res_t;

  // -------------------------------------------------------------------------
  // Output register state
  // -------------------------------------------------------------------------
  logic                 out_valid_reg,      out_valid_next;
  logic                 out_we_reg,         out_we_next;
  logic [T_W-1:0]       out_t_reg,          out_t_next;
  logic [REG_ID_W-1:0]  out_reg_id_reg,     out_reg_id_next;
  logic [DATA_W-1:0]    out_pc_reg,         out_pc_next;
  logic [DATA_W-1:0]    out_store_data_reg, out_store_data_next;
  logic [DATA_W-1:0]    out_data_reg,       out_data_next;
  logic [PAYLOAD_W-1:0] out_payload_reg,    out_payload_next;

  // -------------------------------------------------------------------------
  // Bypass source list, packed with source 0 (own register) in the low slice
  // so the scan order below is also the priority order.
  // -------------------------------------------------------------------------
  logic [NSRC-1:0]          src_act;
  logic [NSRC*REG_ID_W-1:0] src_id;
  logic [NSRC*T_W-1:0]      src_t;
  logic [NSRC*DATA_W-1:0]   src_data;

  assign src_act  = {fwd_we,     out_valid_reg & out_we_reg};
  assign src_id   = {fwd_reg_id, out_reg_id_reg};
  assign src_t    = {fwd_t,      out_t_reg};
  assign src_data = {fwd_data,   out_data_reg};

  // Resolve one operand against the source list. Only the first (highest
  // priority) match is considered; its countdown decides between forwarding
  // its data and flagging a hazard. Register 0 never forwards or stalls.
  function automatic opnd_res_t resolve_opnd(
    input logic [REG_ID_W-1:0]      id,
    input logic [DATA_W-1:0]        rf_data,
    input logic [NSRC-1:0]          act,
    input logic [NSRC*REG_ID_W-1:0] ids,
    input logic [NSRC*T_W-1:0]      ts,
    input logic [NSRC*DATA_W-1:0]   datas
  );
    opnd_res_t res;
    logic      hit;
    res.haz = 1'b0;
    res.val = rf_data;
    hit     = 1'b0;
    if (id != '0) begin
      for (int s = 0; s < NSRC; s++) begin
        if (!hit && act[s] && (ids[s*REG_ID_W +: REG_ID_W] == id)) begin
          hit = 1'b1;
          if (ts[s*T_W +: T_W] == '0) begin
            res.val = datas[s*DATA_W +: DATA_W];
          end else begin
            res.haz = 1'b1;
          end
        end
      end
    end
    return res;
  endfunction

  // -------------------------------------------------------------------------
  // Operand forwarding: rs and rt are resolved independently by identical
  // copies of the network.
  // -------------------------------------------------------------------------
  logic [REG_ID_W-1:0] opnd_id  [NUM_OPND];
  logic [DATA_W-1:0]   opnd_rf  [NUM_OPND];
  opnd_res_t           opnd_res [NUM_OPND];

  assign opnd_id[0] = in_rs_id;
  assign opnd_id[1] = in_rt_id;
  assign opnd_rf[0] = in_rs_data;
  assign opnd_rf[1] = in_rt_data;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OPND; gi++) begin : g_opnd
      assign opnd_res[gi] = resolve_opnd(opnd_id[gi], opnd_rf[gi], src_act,
                                         src_id, src_t, src_data);
    end
  endgenerate

  assign op_rs = opnd_res[0].val;
  assign op_rt = opnd_res[1].val;

  // A hazard only matters when there is actually an instruction waiting.
  assign hazard = (opnd_res[0].haz | opnd_res[1].haz) & in_valid;

  assign in_ready = !flush && !mc_busy && !hazard &&
                    (!out_valid_reg || out_ready);

  logic capture;
  assign capture = in_valid & in_ready;

  // -------------------------------------------------------------------------
  // Countdown arithmetic: unsigned, saturating at zero.
  // -------------------------------------------------------------------------
  logic [T_W-1:0] in_t_dec;
  logic [T_W-1:0] out_t_dec;

  assign in_t_dec  = (in_t      == '0) ? '0 : in_t      - T_W'(1);
  assign out_t_dec = (out_t_reg == '0) ? '0 : out_t_reg - T_W'(1);

  // -------------------------------------------------------------------------
  // Next-state logic. Priority: flush > capture > bubble > hold.
  // -------------------------------------------------------------------------
  always_comb begin
    // Hold by default. The countdown keeps ticking while an instruction is
    // stalled in the register; this is what eventually releases a consumer
    // that depends on it.
    out_valid_next      = out_valid_reg;
    out_we_next         = out_we_reg;
    out_t_next          = out_t_dec;
    out_reg_id_next     = out_reg_id_reg;
    out_pc_next         = out_pc_reg;
    out_store_data_next = out_store_data_reg;
    out_data_next       = out_data_reg;
    out_payload_next    = out_payload_reg;

    if (flush) begin
      // PC and payload survive a flush so the exception handler can still
      // see the EPC and the exception flags of the flushed instruction.
      out_valid_next      = 1'b0;
      out_we_next         = 1'b0;
      out_t_next          = '0;
      out_reg_id_next     = '0;
      out_store_data_next = '0;
      out_data_next       = '0;
    end else if (capture) begin
      out_valid_next      = 1'b1;
      out_we_next         = in_we;
      out_t_next          = in_t_dec;
      out_reg_id_next     = in_reg_id;
      out_pc_next         = in_pc;
      out_store_data_next = op_rt;
      out_data_next       = alu_result;
      out_payload_next    = in_payload;
    end else if (out_valid_reg && out_ready) begin
      // Downstream took the instruction and nothing replaces it. Clearing
      // we also removes the register from the bypass source list.
      out_valid_next = 1'b0;
      out_we_next    = 1'b0;
      out_t_next     = '0;
    end
  end

  // -------------------------------------------------------------------------
  // Output register
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      out_valid_reg      <= 1'b0;
      out_we_reg         <= 1'b0;
      out_t_reg          <= '0;
      out_reg_id_reg     <= '0;
      out_pc_reg         <= '0;
      out_store_data_reg <= '0;
      out_data_reg       <= '0;
      out_payload_reg    <= '0;
    end else begin
      out_valid_reg      <= out_valid_next;
      out_we_reg         <= out_we_next;
      out_t_reg          <= out_t_next;
      out_reg_id_reg     <= out_reg_id_next;
      out_pc_reg         <= out_pc_next;
      out_store_data_reg <= out_store_data_next;
      out_data_reg       <= out_data_next;
      out_payload_reg    <= out_payload_next;
    end
  end

  assign out_valid      = out_valid_reg;
  assign out_we         = out_we_reg;
  assign out_t          = out_t_reg;
  assign out_reg_id     = out_reg_id_reg;
  assign out_pc         = out_pc_reg;
  assign out_store_data = out_store_data_reg;
  assign out_data       = out_data_reg;
  assign out_payload    = out_payload_reg;

endmodule

// File: tb/tb_ex_fwd_stage_reg.sv
// Bench for ex_fwd_stage_reg. Inputs are driven 2 time units after the rising
// edge; combinational outputs are checked a few units later, and the
// scoreboard monitor compares the output register on the falling edge.
module tb_ex_fwd_stage_reg;

  localparam int DATA_W    = 32;
  localparam int REG_ID_W  = 5;
  localparam int T_W       = 4;
  localparam int NUM_FWD   = 2;
  localparam int PAYLOAD_W = 64;

  logic                        Clk;
  logic                        Clr;
  logic                        flush;
  logic                        mc_busy;
  logic                        in_valid;
  logic                        in_ready;
  logic [DATA_W-1:0]           in_pc;
  logic [REG_ID_W-1:0]         in_rs_id;
  logic [REG_ID_W-1:0]         in_rt_id;
  logic [DATA_W-1:0]           in_rs_data;
  logic [DATA_W-1:0]           in_rt_data;
  logic [T_W-1:0]              in_t;
  logic                        in_we;
  logic [REG_ID_W-1:0]         in_reg_id;
  logic [PAYLOAD_W-1:0]        in_payload;
  logic [NUM_FWD-1:0]          fwd_we;
  logic [NUM_FWD*T_W-1:0]      fwd_t;
  logic [NUM_FWD*REG_ID_W-1:0] fwd_reg_id;
  logic [NUM_FWD*DATA_W-1:0]   fwd_data;
  logic [DATA_W-1:0]           op_rs;
  logic [DATA_W-1:0]           op_rt;
  logic [DATA_W-1:0]           alu_result;
  logic                        hazard;
  logic                        out_valid;
  logic                        out_ready;
  logic [DATA_W-1:0]           out_pc;
  logic [DATA_W-1:0]           out_store_data;
  logic [DATA_W-1:0]           out_data;
  logic [T_W-1:0]              out_t;
  logic                        out_we;
  logic [REG_ID_W-1:0]         out_reg_id;
  logic [PAYLOAD_W-1:0]        out_payload;

  ex_fwd_stage_reg #(
    .DATA_W(DATA_W), .REG_ID_W(REG_ID_W), .T_W(T_W),
    .NUM_FWD(NUM_FWD), .PAYLOAD_W(PAYLOAD_W)
  ) dut (
    .Clk(Clk), .Clr(Clr), .flush(flush), .mc_busy(mc_busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_rs_id(in_rs_id), .in_rt_id(in_rt_id),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
    .in_t(in_t), .in_we(in_we), .in_reg_id(in_reg_id), .in_payload(in_payload),
    .fwd_we(fwd_we), .fwd_t(fwd_t), .fwd_reg_id(fwd_reg_id), .fwd_data(fwd_data),
    .op_rs(op_rs), .op_rt(op_rt), .alu_result(alu_result), .hazard(hazard),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_store_data(out_store_data), .out_data(out_data), .out_t(out_t),
    .out_we(out_we), .out_reg_id(out_reg_id), .out_payload(out_payload)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  // Scoreboard entry: what the output register must show when handed off.
  typedef struct {
    logic [DATA_W-1:0]    pc;
    logic [DATA_W-1:0]    st;
    logic [DATA_W-1:0]    data;
    logic [T_W-1:0]       t_in;
    logic                 we;
    logic [REG_ID_W-1:0]  id;
    logic [PAYLOAD_W-1:0] pl;
    int                   cyc;
  } exp_t;

  exp_t sb[$];

  // Monitor: on every downstream handshake, pop and compare. The countdown
  // expected at hand-off is in_t minus the cycles spent in the register,
  // saturating at zero.
  exp_t           mon_e;
  int             mon_tv;
  logic [T_W-1:0] mon_t;
  always @(negedge Clk) begin
    if (!Clr && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got out_valid=1 pc=%h, expected no transaction", out_pc);
      end else begin
        mon_e  = sb.pop_front();
        mon_tv = int'(mon_e.t_in) - (cyc - mon_e.cyc);
        if (mon_tv < 0) mon_tv = 0;
        mon_t  = T_W'(mon_tv);
        $display("txn pc=%h st=%h data=%h t=%0d we=%b id=%0d pl=%h",
                 out_pc, out_store_data, out_data, out_t, out_we, out_reg_id, out_payload);
        if ({out_pc, out_store_data, out_data, out_t, out_we, out_reg_id, out_payload} !==
            {mon_e.pc, mon_e.st, mon_e.data, mon_t, mon_e.we, mon_e.id, mon_e.pl}) begin
          errors++;
          $display("FAIL sb_txn: got pc=%h st=%h data=%h t=%0d we=%b id=%0d pl=%h, expected pc=%h st=%h data=%h t=%0d we=%b id=%0d pl=%h",
                   out_pc, out_store_data, out_data, out_t, out_we, out_reg_id, out_payload,
                   mon_e.pc, mon_e.st, mon_e.data, mon_t, mon_e.we, mon_e.id, mon_e.pl);
        end
      end
    end
  end

  // ---------------- stimulus helpers (drive only) ----------------
  task automatic step;
    @(posedge Clk);
    #2;
  endtask

  task automatic set_fwd(input int i, input logic we, input logic [T_W-1:0] t,
                         input logic [REG_ID_W-1:0] id, input logic [DATA_W-1:0] d);
    fwd_we[i]                      = we;
    fwd_t[i*T_W +: T_W]            = t;
    fwd_reg_id[i*REG_ID_W +: REG_ID_W] = id;
    fwd_data[i*DATA_W +: DATA_W]   = d;
  endtask

  task automatic idle;
    flush = 1'b0; mc_busy = 1'b0; in_valid = 1'b0;
    in_pc = '0; in_rs_id = '0; in_rt_id = '0; in_rs_data = '0; in_rt_data = '0;
    in_t = '0; in_we = 1'b0; in_reg_id = '0; in_payload = '0; alu_result = '0;
    fwd_we = '0; fwd_t = '0; fwd_reg_id = '0; fwd_data = '0;
  endtask

  task automatic drive_instr(input logic [DATA_W-1:0] pc, input logic [REG_ID_W-1:0] rs,
                             input logic [REG_ID_W-1:0] rt, input logic [DATA_W-1:0] rsd,
                             input logic [DATA_W-1:0] rtd, input logic [T_W-1:0] t,
                             input logic we, input logic [REG_ID_W-1:0] id,
                             input logic [PAYLOAD_W-1:0] pl, input logic [DATA_W-1:0] alu);
    in_valid = 1'b1; in_pc = pc; in_rs_id = rs; in_rt_id = rt;
    in_rs_data = rsd; in_rt_data = rtd; in_t = t; in_we = we;
    in_reg_id = id; in_payload = pl; alu_result = alu;
  endtask

  task automatic push(input logic [DATA_W-1:0] pc, input logic [DATA_W-1:0] st,
                      input logic [DATA_W-1:0] data, input logic [T_W-1:0] t,
                      input logic we, input logic [REG_ID_W-1:0] id,
                      input logic [PAYLOAD_W-1:0] pl);
    exp_t e;
    e.pc = pc; e.st = st; e.data = data; e.t_in = t; e.we = we;
    e.id = id; e.pl = pl; e.cyc = cyc;
    sb.push_back(e);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    Clr = 1'b1; out_ready = 1'b0; idle();
    step(); step();
    checks++;
    if ({out_valid, out_we, out_t, out_reg_id, out_pc, out_store_data, out_data, out_payload} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b pc=%h data=%h t=%0d, expected all zero",
               out_valid, out_pc, out_data, out_t);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    Clr = 1'b0;
    step();
  endtask

  task automatic test_fwd_priority;
    out_ready = 1'b0; idle();
    drive_instr(32'h100, 5'd0, 5'd0, 32'h0, 32'h5, 4'd0, 1'b1, 5'd5, 64'hA1, 32'h11);
    push(32'h100, 32'h5, 32'h11, 4'd0, 1'b1, 5'd5, 64'hA1);
    step();
    idle(); in_valid = 1'b1; in_rs_id = 5'd5; in_rs_data = 32'h99;
    set_fwd(0, 1'b1, 4'd0, 5'd5, 32'h22);
    #1;
    checks++;
    if (op_rs !== 32'h11) begin
      errors++; $display("FAIL fwd_prio_own: got op_rs=%h expected 11", op_rs);
    end
    checks++;
    if ({hazard, in_ready} !== 2'b00) begin
      errors++; $display("FAIL fwd_prio_stall: got hazard=%b in_ready=%b expected 0 0", hazard, in_ready);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    #1;
    checks++;
    if (op_rs !== 32'h22 || out_valid !== 1'b0) begin
      errors++; $display("FAIL fwd_prio_ext: got op_rs=%h out_valid=%b expected 22 0", op_rs, out_valid);
    end
    in_valid = 1'b1; in_rt_id = 5'd5; in_pc = 32'h104; alu_result = 32'h33;
    in_t = 4'd2; in_we = 1'b0; in_reg_id = 5'd3; in_payload = 64'hA2;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL fwd_prio_ready: got in_ready=%b expected 1", in_ready);
    end
    push(32'h104, 32'h22, 32'h33, 4'd2, 1'b0, 5'd3, 64'hA2);
    step(); idle(); step();
  endtask

  task automatic test_load_use;
    out_ready = 1'b1; idle();
    set_fwd(0, 1'b1, 4'd1, 5'd8, 32'h0);
    set_fwd(1, 1'b1, 4'd0, 5'd8, 32'hBEEF);
    drive_instr(32'h200, 5'd0, 5'd8, 32'h0, 32'h777, 4'd0, 1'b1, 5'd9, 64'hB1, 32'h44);
    #1;
    checks++;
    if ({hazard, in_ready} !== 2'b10) begin
      errors++; $display("FAIL load_use_stall: got hazard=%b in_ready=%b expected 1 0", hazard, in_ready);
    end
    step();
    set_fwd(0, 1'b1, 4'd0, 5'd8, 32'hDEAD);
    #1;
    checks++;
    if ({hazard, in_ready} !== 2'b01 || op_rt !== 32'hDEAD) begin
      errors++; $display("FAIL load_use_release: got hazard=%b in_ready=%b op_rt=%h expected 0 1 dead",
                         hazard, in_ready, op_rt);
    end
    push(32'h200, 32'hDEAD, 32'h44, 4'd0, 1'b1, 5'd9, 64'hB1);
    step(); idle();
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_store_data !== 32'hDEAD) begin
      errors++; $display("FAIL load_use_out: got valid=%b store=%h expected 1 dead", out_valid, out_store_data);
    end
    step();
  endtask

  task automatic test_self_hazard;
    logic [T_W-1:0] te;
    out_ready = 1'b0; idle();
    drive_instr(32'h300, 5'd0, 5'd0, 32'h0, 32'h31, 4'd3, 1'b1, 5'd7, 64'hC1, 32'h77);
    push(32'h300, 32'h31, 32'h77, 4'd3, 1'b1, 5'd7, 64'hC1);
    step();
    idle(); in_valid = 1'b1; in_rs_id = 5'd7; in_rs_data = 32'h1;
    for (int k = 0; k < 3; k++) begin
      #1;
      te = T_W'(2 - k);
      checks++;
      if (out_t !== te || hazard !== (k < 2) || in_ready !== 1'b0) begin
        errors++; $display("FAIL self_haz_k%0d: got out_t=%0d hazard=%b in_ready=%b expected %0d %b 0",
                           k, out_t, hazard, in_ready, te, (k < 2));
      end
      if (k < 2) step();
    end
    checks++;
    if (op_rs !== 32'h77) begin
      errors++; $display("FAIL self_haz_fwd: got op_rs=%h expected 77", op_rs);
    end
    out_ready = 1'b1;
    in_pc = 32'h304; in_rt_data = 32'h9; alu_result = 32'h78; in_t = 4'd0;
    in_we = 1'b0; in_reg_id = 5'd2; in_payload = 64'hC2;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL self_haz_ready: got in_ready=%b expected 1", in_ready);
    end
    push(32'h304, 32'h9, 32'h78, 4'd0, 1'b0, 5'd2, 64'hC2);
    step(); idle(); step();
  endtask

  task automatic test_zero_reg;
    out_ready = 1'b1; idle();
    set_fwd(0, 1'b1, 4'd2, 5'd0, 32'h55);
    set_fwd(1, 1'b1, 4'd2, 5'd0, 32'h56);
    drive_instr(32'h400, 5'd0, 5'd0, 32'hABC, 32'h123, 4'd1, 1'b1, 5'd0, 64'hD1, 32'h66);
    #1;
    checks++;
    if (hazard !== 1'b0 || op_rs !== 32'hABC || op_rt !== 32'h123 || in_ready !== 1'b1) begin
      errors++; $display("FAIL zero_reg: got hazard=%b op_rs=%h op_rt=%h in_ready=%b expected 0 abc 123 1",
                         hazard, op_rs, op_rt, in_ready);
    end
    push(32'h400, 32'h123, 32'h66, 4'd1, 1'b1, 5'd0, 64'hD1);
    step(); idle(); step();
  endtask

  task automatic test_flush;
    out_ready = 1'b0; idle();
    drive_instr(32'h80, 5'd0, 5'd0, 32'h0, 32'h8, 4'd0, 1'b1, 5'd4, 64'hE1, 32'h88);
    push(32'h80, 32'h8, 32'h88, 4'd0, 1'b1, 5'd4, 64'hE1);
    step();
    drive_instr(32'h84, 5'd0, 5'd0, 32'h0, 32'h0, 4'd0, 1'b1, 5'd6, 64'hE2, 32'h99);
    out_ready = 1'b1; flush = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL flush_ready: got in_ready=%b expected 0", in_ready);
    end
    step(); idle();
    #1;
    checks++;
    if ({out_valid, out_we} !== 2'b00 || out_pc !== 32'h80 || out_payload !== 64'hE1) begin
      errors++; $display("FAIL flush_keep: got valid=%b we=%b pc=%h pl=%h expected 0 0 80 e1",
                         out_valid, out_we, out_pc, out_payload);
    end
    checks++;
    if ({out_t, out_reg_id, out_data, out_store_data} !== '0) begin
      errors++; $display("FAIL flush_clear: got t=%0d id=%0d data=%h st=%h expected 0",
                         out_t, out_reg_id, out_data, out_store_data);
    end
    step();
  endtask

  task automatic test_back_to_back;
    logic [DATA_W-1:0]    d, rtd, prev_val, st;
    logic [PAYLOAD_W-1:0] pl;
    logic [REG_ID_W-1:0]  prev_id, id;
    out_ready = 1'b1; idle();
    prev_id = '0; prev_val = '0;
    for (int i = 0; i < 6; i++) begin
      d   = $urandom;
      rtd = $urandom;
      pl  = {$urandom, $urandom};
      id  = REG_ID_W'(16 + i);
      st  = (i == 0) ? rtd : prev_val;
      drive_instr(32'h600 + DATA_W'(4 * i), prev_id, prev_id, 32'h0, rtd,
                  T_W'(i % 2), 1'b1, id, pl, d);
      #1;
      checks++;
      if (in_ready !== 1'b1 || op_rt !== st) begin
        errors++; $display("FAIL b2b_%0d: got in_ready=%b op_rt=%h expected 1 %h", i, in_ready, op_rt, st);
      end
      push(32'h600 + DATA_W'(4 * i), st, d, T_W'(i % 2), 1'b1, id, pl);
      step();
      prev_id = id; prev_val = d;
    end
    idle(); step(); step();
  endtask

  task automatic test_mc_busy_reset;
    out_ready = 1'b0; idle();
    drive_instr(32'h500, 5'd0, 5'd0, 32'h0, 32'h5, 4'd2, 1'b1, 5'd11, 64'hF1, 32'h5A);
    push(32'h500, 32'h5, 32'h5A, 4'd2, 1'b1, 5'd11, 64'hF1);
    step();
    drive_instr(32'h504, 5'd0, 5'd0, 32'h0, 32'h6, 4'd0, 1'b1, 5'd13, 64'hF2, 32'h6B);
    mc_busy = 1'b1; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL mc_busy_ready: got in_ready=%b expected 0", in_ready);
    end
    for (int k = 0; k < 2; k++) begin
      step();
      #1;
      checks++;
      if ({out_valid, out_we} !== 2'b00) begin
        errors++; $display("FAIL mc_busy_bubble_%0d: got valid=%b we=%b expected 0 0", k, out_valid, out_we);
      end
    end
    mc_busy = 1'b0; out_ready = 1'b0;
    drive_instr(32'h508, 5'd0, 5'd0, 32'h0, 32'h7, 4'd3, 1'b1, 5'd12, 64'hF3, 32'hC0FFEE);
    push(32'h508, 32'h7, 32'hC0FFEE, 4'd3, 1'b1, 5'd12, 64'hF3);
    step(); idle();
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h508) begin
      errors++; $display("FAIL pre_clr: got valid=%b pc=%h expected 1 508", out_valid, out_pc);
    end
    Clr = 1'b1;
    sb.delete();
    #1;
    checks++;
    if ({out_valid, out_we, out_t, out_reg_id, out_pc, out_store_data, out_data, out_payload} !== '0) begin
      errors++; $display("FAIL async_clr: got valid=%b pc=%h data=%h t=%0d pl=%h expected all zero",
                         out_valid, out_pc, out_data, out_t, out_payload);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL async_clr_ready: got in_ready=%b expected 1", in_ready);
    end
    step();
    Clr = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_fwd_priority();
    test_load_use();
    test_self_hazard();
    test_zero_reg();
    test_flush();
    test_back_to_back();
    test_mc_busy_reset();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_drain: got %0d pending entries expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
